// File: rtl/phy_tx_arbiter.sv
// Two-requester burst arbiter feeding a registered word stream to PHY_TX.
// Optional idle comma fill: define TX_ARB_IDLE_FILL_EN.
module phy_tx_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter logic [31:0] IDLE_WORD = 32'hBCBC_BCBC
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic        link_en,
    input  logic        valid_0,
    input  logic [31:0] data_0,
    output logic        ready_0,
    input  logic        valid_1,
    input  logic [31:0] data_1,
    output logic        ready_1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        grant_id
);

    typedef enum logic [1:0] {StIdle, StServe0, StServe1} state_e;

    localparam logic [3:0] BurstMax = 4'(MAX_BURST);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        gid_q, gid_d;

    logic serve_id, valid_cur, valid_oth, accept, arb_any, arb_sel, grant_end;

    always_comb begin
        serve_id  = (state_q == StServe1);
        valid_cur = serve_id ? valid_1 : valid_0;
        valid_oth = serve_id ? valid_0 : valid_1;
        ready_0   = (state_q == StServe0) & link_en & valid_0;
        ready_1   = (state_q == StServe1) & link_en & valid_1;
        accept    = ready_0 | ready_1;
        arb_any   = valid_0 | valid_1;
        // On a tie the requester not served last wins.
        arb_sel   = (valid_0 & valid_1) ? ~last_q : valid_1;
        grant_end = ~valid_cur | ((cnt_q + 4'd1) == BurstMax);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (!link_en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StIdle) begin
            if (arb_any) begin
                state_d = arb_sel ? StServe1 : StServe0;
                cnt_d   = '0;
            end
        end else begin
            if (accept) begin
                last_d = serve_id;
                cnt_d  = cnt_q + 4'd1;
            end
            // A lone requester re-arbitrates through IDLE, leaving one gap word.
            if (grant_end) begin
                cnt_d   = '0;
                state_d = valid_oth ? (serve_id ? StServe0 : StServe1) : StIdle;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        gid_d   = gid_q;
        if (accept) begin
            data_d  = serve_id ? data_1 : data_0;
            valid_d = 1'b1;
            gid_d   = serve_id;
        end else begin
`ifdef TX_ARB_IDLE_FILL_EN
            data_d  = IDLE_WORD;
            valid_d = link_en;
`endif
        end
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            data_q  <= IDLE_WORD;
            valid_q <= 1'b0;
            gid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            gid_q   <= gid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign grant_id  = gid_q;

endmodule
